// File: rtl/imm_gen_pipe_pkg.sv
// Shared opcode constants, immediate format codes and the opcode-to-format
// lookup for the RV32I immediate generator.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_FMT_NONE = 3'd0,
    IMM_FMT_I    = 3'd1,
    IMM_FMT_S    = 3'd2,
    IMM_FMT_B    = 3'd3,
    IMM_FMT_U    = 3'd4,
    IMM_FMT_J    = 3'd5
  } imm_fmt_e;

  // Opcodes without the 2'b11 suffix never match, so they fall into NONE.
  function automatic imm_fmt_e opc_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: opc_fmt = IMM_FMT_I;
      OPC_STORE:                                  opc_fmt = IMM_FMT_S;
      OPC_BRANCH:                                 opc_fmt = IMM_FMT_B;
      OPC_LUI, OPC_AUIPC:                         opc_fmt = IMM_FMT_U;
      OPC_JAL:                                    opc_fmt = IMM_FMT_J;
      default:                                    opc_fmt = IMM_FMT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen_stage.sv
// One valid/ready register slice; the load strobe is computed by the parent
// so the ready chain stays free of combinational loops through the slices.
module imm_gen_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (flush)     out_valid <= 1'b0;
      else if (load) out_valid <= in_valid;
      // Data only moves with a real beat, so a stalled or drained slice keeps its contents.
      if (load && in_valid && !flush) out_data <= in_data;
    end
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I immediate generator: combinational decode feeding
// PIPE_DEPTH valid/ready slices, plus a saturating illegal-instruction counter.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int PIPE_DEPTH = 1,
  parameter int TAG_W      = 32,
  parameter int CNT_W      = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_Instruction,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_ExtendedImmediate,
  output logic [2:0]       o_fmt,
  output logic             o_illegal,
  output logic [TAG_W-1:0] o_tag,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam int PW = XLEN + 3 + 1 + TAG_W;

  imm_fmt_e           dec_fmt;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_illegal;

  always_comb begin
    dec_fmt   = opc_fmt(i_Instruction[6:0]);
    dec_imm32 = '0;
    case (dec_fmt)
      IMM_FMT_I: dec_imm32 = {{20{i_Instruction[31]}}, i_Instruction[31:20]};
      IMM_FMT_S: dec_imm32 = {{20{i_Instruction[31]}}, i_Instruction[31:25], i_Instruction[11:7]};
      IMM_FMT_B: dec_imm32 = {{20{i_Instruction[31]}}, i_Instruction[7], i_Instruction[30:25],
                              i_Instruction[11:8], 1'b0};
      IMM_FMT_U: dec_imm32 = {i_Instruction[31:12], 12'b0};
      IMM_FMT_J: dec_imm32 = {{12{i_Instruction[31]}}, i_Instruction[19:12], i_Instruction[20],
                              i_Instruction[30:21], 1'b0};
      default:   dec_imm32 = '0;
    endcase
    dec_illegal = (dec_fmt == IMM_FMT_NONE);
    dec_imm     = XLEN'(dec_imm32);
  end

  // vld_pipe[0]/data_pipe[0] are the input beat; index k+1 is slice k's register.
  logic [PIPE_DEPTH:0]         vld_pipe;
  logic [PIPE_DEPTH:0][PW-1:0] data_pipe;
  logic [PIPE_DEPTH-1:0]       load;

  assign vld_pipe[0]  = i_valid;
  assign data_pipe[0] = {dec_imm, dec_fmt, dec_illegal, i_tag};

  // Slice k loads when any slice at or after it is empty, or the consumer takes the head.
  always_comb begin
    logic acc;
    acc  = i_ready;
    load = '0;
    for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
      acc     = acc | ~vld_pipe[k+1];
      load[k] = acc;
    end
  end

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_slice
    imm_gen_stage #(.W(PW)) u_stage (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .flush    (i_flush),
      .load     (load[k]),
      .in_valid (vld_pipe[k]),
      .in_data  (data_pipe[k]),
      .out_valid(vld_pipe[k+1]),
      .out_data (data_pipe[k+1])
    );
  end

  assign o_ready = load[0];
  assign o_valid = vld_pipe[PIPE_DEPTH];
  assign {o_ExtendedImmediate, o_fmt, o_illegal, o_tag} = data_pipe[PIPE_DEPTH];

  logic accept;
  assign accept = i_valid & o_ready & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                       o_illegal_cnt <= '0;
    else if (accept && dec_illegal && o_illegal_cnt != '1) o_illegal_cnt <= o_illegal_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised scoreboard bench for imm_gen_pipe with a few directed sequences
// whose expected immediates are written out by hand.
module tb_imm_gen_pipe;

  localparam int XLEN  = 32;
  localparam int D     = 2;
  localparam int TAG_W = 32;
  localparam int CNT_W = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_flush = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [31:0]      i_Instruction = '0;
  logic [TAG_W-1:0] i_tag = '0;
  logic             o_valid;
  logic             i_ready = 1'b0;
  logic [XLEN-1:0]  o_ExtendedImmediate;
  logic [2:0]       o_fmt;
  logic             o_illegal;
  logic [TAG_W-1:0] o_tag;
  logic [CNT_W-1:0] o_illegal_cnt;

  imm_gen_pipe #(.XLEN(XLEN), .PIPE_DEPTH(D), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_Instruction(i_Instruction), .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_ExtendedImmediate(o_ExtendedImmediate), .o_fmt(o_fmt), .o_illegal(o_illegal),
    .o_tag(o_tag), .o_illegal_cnt(o_illegal_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
    int          vis;
  } item_t;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } lit_t;

  item_t q[$];
  lit_t  lit_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    exp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference decode straight from the RV32I immediate layouts.
  function automatic void ref_dec(input logic [31:0] ins, output logic [31:0] imm,
                                  output logic [2:0] fmt, output logic ill);
    imm = 32'd0; fmt = 3'd0; ill = 1'b0;
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin fmt = 3'd1; imm = 32'($signed(ins[31:20])); end
      7'h23: begin fmt = 3'd2; imm = 32'($signed({ins[31:25], ins[11:7]})); end
      7'h63: begin fmt = 3'd3; imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0})); end
      7'h37, 7'h17: begin fmt = 3'd4; imm = ins & 32'hFFFF_F000; end
      7'h6F: begin fmt = 3'd5; imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0})); end
      default: ill = 1'b1;
    endcase
  endfunction

  // One cycle: drive at negedge, compare at negedge+1, advance the model to the next edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                      input logic rdy, input logic fl, output logic acc);
    logic exp_rdy, exp_vld, out_x;
    item_t it;
    @(negedge i_clk);
    i_valid = v; i_Instruction = ins; i_tag = tag; i_ready = rdy; i_flush = fl;
    #1;
    exp_rdy = (q.size() < D) || rdy;
    exp_vld = (q.size() > 0) && (cyc >= q[0].vis);
    chk("o_ready", 64'(o_ready), 64'(exp_rdy));
    chk("o_valid", 64'(o_valid), 64'(exp_vld));
    chk("illegal_cnt", 64'(o_illegal_cnt), 64'(exp_cnt));
    if (exp_vld) begin
      chk("imm", 64'(o_ExtendedImmediate), 64'(q[0].imm));
      chk("fmt", 64'(o_fmt), 64'(q[0].fmt));
      chk("illegal", 64'(o_illegal), 64'(q[0].ill));
      chk("tag", 64'(o_tag), 64'(q[0].tag));
    end
    out_x = exp_vld && rdy;
    if (out_x && lit_q.size() > 0) begin
      chk("lit_imm", 64'(o_ExtendedImmediate), 64'(lit_q[0].imm));
      chk("lit_fmt", 64'(o_fmt), 64'(lit_q[0].fmt));
      chk("lit_illegal", 64'(o_illegal), 64'(lit_q[0].ill));
      void'(lit_q.pop_front());
    end
    acc = v && exp_rdy && !fl;
    if (out_x) begin
      void'(q.pop_front());
      if (q.size() > 0 && q[0].vis < cyc + 1) q[0].vis = cyc + 1;
    end
    if (fl) q.delete();
    if (acc) begin
      ref_dec(ins, it.imm, it.fmt, it.ill);
      it.tag = tag;
      it.vis = cyc + D;
      if (it.ill && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      q.push_back(it);
    end
    @(posedge i_clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, a);
  endtask

  task automatic send_lit(input logic [31:0] ins, input logic [31:0] imm, input logic [2:0] fmt,
                          input logic ill);
    logic a;
    lit_t l;
    l.imm = imm; l.fmt = fmt; l.ill = ill;
    lit_q.push_back(l);
    step(1'b1, ins, ins ^ 32'hA5A5_0000, 1'b1, 1'b0, a);
    chk("lit_accept", 64'(a), 64'd1);
  endtask

  task automatic mid_reset();
    @(negedge i_clk);
    i_valid = 1'b0; i_flush = 1'b0;
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_cnt", 64'(o_illegal_cnt), 64'd0);
    chk("rst_tag", 64'(o_tag), 64'd0);
    #1 i_rst_n = 1'b1;
    q.delete(); lit_q.delete(); exp_cnt = 0;
    @(posedge i_clk);
    cyc++;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  opcs[9] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    logic [31:0] r;
    int          sel;
    r   = $urandom();
    sel = $urandom_range(0, 11);
    if (sel < 9)       return {r[31:7], opcs[sel]};
    else if (sel == 9) return r;
    else if (sel == 10) return 32'd0;
    else               return {r[31:7], 7'h33};
  endfunction

  task automatic random_run(input int n);
    logic [31:0] ins, tag;
    logic v, pend, a;
    pend = 1'b0; ins = '0; tag = '0; v = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pend) begin
        v   = ($urandom_range(0, 3) != 0);
        ins = rand_ins();
        tag = $urandom();
      end
      step(v, ins, tag, ($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), a);
      pend = v && !a;
    end
  endtask

  logic [31:0] m_imm;
  logic [2:0]  m_fmt;
  logic        m_ill;
  logic        acc_f;

  initial begin
    #1;
    chk("reset_o_valid", 64'(o_valid), 64'd0);
    chk("reset_o_fmt", 64'(o_fmt), 64'd0);
    chk("reset_o_illegal", 64'(o_illegal), 64'd0);
    chk("reset_o_tag", 64'(o_tag), 64'd0);
    chk("reset_imm", 64'(o_ExtendedImmediate), 64'd0);
    chk("reset_cnt", 64'(o_illegal_cnt), 64'd0);
    #11 i_rst_n = 1'b1;

    // Pin the reference decoder itself against hand-worked encodings.
    ref_dec(32'hFE00_0EE3, m_imm, m_fmt, m_ill);
    chk("model_beq_imm", 64'(m_imm), 64'hFFFF_FFFC);
    ref_dec(32'h7FE0_006F, m_imm, m_fmt, m_ill);
    chk("model_jal_imm", 64'(m_imm), 64'h0000_07FE);
    ref_dec(32'h0000_007F, m_imm, m_fmt, m_ill);
    chk("model_illegal", 64'({m_ill, m_fmt}), 64'h8);

    // ADDI x1,x0,-1 alone, then four back-to-back formats.
    send_lit(32'hFFF0_0093, 32'hFFFF_FFFF, 3'd1, 1'b0);
    idle(D + 1);
    send_lit(32'hFE11_2E23, 32'hFFFF_FFFC, 3'd2, 1'b0);
    send_lit(32'hFE00_0EE3, 32'hFFFF_FFFC, 3'd3, 1'b0);
    send_lit(32'h1234_50B7, 32'h1234_5000, 3'd4, 1'b0);
    send_lit(32'h7FE0_006F, 32'h0000_07FE, 3'd5, 1'b0);
    idle(D + 2);
    chk("lit_drained", 64'(lit_q.size()), 64'd0);

    // Illegal words and counter saturation at 2'b11.
    send_lit(32'h0000_0000, 32'd0, 3'd0, 1'b1);
    send_lit(32'h0000_007F, 32'd0, 3'd0, 1'b1);
    idle(D + 1);
    chk("cnt_two", 64'(o_illegal_cnt), 64'd2);
    for (int i = 0; i < 3; i++) send_lit(32'h0000_0033 + 32'(i << 12), 32'd0, 3'd0, 1'b1);
    idle(D + 1);
    chk("cnt_saturated", 64'(o_illegal_cnt), 64'd3);

    // Stall with a full pipe, then release.
    for (int i = 0; i < D + 5; i++) begin
      step(1'b1, 32'h0010_0013 + 32'(i << 20), 32'h100 + 32'(i), 1'b0, 1'b0, acc_f);
      if (i >= D) chk("stall_no_accept", 64'(acc_f), 64'd0);
    end
    idle(D + 2);

    // Flush with a concurrent input while full.
    for (int i = 0; i < D; i++) step(1'b1, 32'h0020_0013, 32'h200 + 32'(i), 1'b0, 1'b0, acc_f);
    step(1'b1, 32'h0030_0013, 32'hDEAD_BEEF, 1'b1, 1'b1, acc_f);
    idle(D + 2);

    random_run(400);
    mid_reset();
    random_run(400);
    idle(D + 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
